// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage of the THCO-MIPS pipeline.
//
// Owns the PC, drives the instruction ROM (zero-latency, combinational from
// rom_addr_o) and registers the returned instruction plus its PC into the
// IF/ID pipeline register. Handles hazard stalls, taken branches with one
// delay slot, and flushes to an exception/redirect PC.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   stall_if          hold PC
//   stall_id          hold IF/ID register (also holds PC)
//   branch_flag_i     taken branch resolved in ID this cycle
//   branch_target_i   branch target (bit 0 forced to 0)
//   flush_i           flush to flush_pc_i (bit 0 forced to 0)
//   inst_i            instruction from ROM for rom_addr_o
//   rom_ce_o          ROM chip enable, 0 in the cycle after reset
//   rom_addr_o        ROM address (= current PC)
//   id_pc_o           PC of the instruction in IF/ID
//   id_inst_o         instruction in IF/ID
//   id_valid_o        1 = real instruction, 0 = bubble
module if_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic        branch_flag_i,
  input  logic [15:0] branch_target_i,
  input  logic        flush_i,
  input  logic [15:0] flush_pc_i,
  input  logic [15:0] inst_i,
  output logic        rom_ce_o,
  output logic [15:0] rom_addr_o,
  output logic [15:0] id_pc_o,
  output logic [15:0] id_inst_o,
  output logic        id_valid_o
);

  logic        rom_ce_q,   rom_ce_d;
  logic [15:0] pc_q,       pc_d;
  logic [15:0] id_pc_q,    id_pc_d;
  logic [15:0] id_inst_q,  id_inst_d;
  logic        id_valid_q, id_valid_d;

  // A stalled ID stage must also freeze fetch, otherwise the instruction
  // fetched while ID holds would be lost.
  logic stall_if_e, stall_id_e;
  assign stall_if_e = stall_if | stall_id;
  assign stall_id_e = stall_id;

  always_comb begin
    rom_ce_d = 1'b1;
    pc_d     = pc_q;
    // The first enabled cycle fetches RESET_PC, so the PC only moves once
    // the ROM is already enabled. Flush overrides stalls; a branch seen
    // during a stall is dropped because ID keeps asserting it.
    if (rom_ce_q) begin
      if (flush_i)
        pc_d = {flush_pc_i[15:1], 1'b0};
      else if (!stall_if_e) begin
        if (branch_flag_i)
          pc_d = {branch_target_i[15:1], 1'b0};
        else
          pc_d = pc_q + 16'd2;
      end
    end
  end

  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (flush_i || !rom_ce_q || (stall_if_e && !stall_id_e)) begin
      id_pc_d    = 16'h0000;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else if (!stall_id_e) begin
      // Delay slot: the instruction fetched alongside a taken branch is
      // captured like any other; only the PC is redirected.
      id_pc_d    = pc_q;
      id_inst_d  = inst_i;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rom_ce_q   <= 1'b0;
      pc_q       <= RESET_PC;
      id_pc_q    <= 16'h0000;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      rom_ce_q   <= rom_ce_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign rom_ce_o   = rom_ce_q;
  assign rom_addr_o = pc_q;
  assign id_pc_o    = id_pc_q;
  assign id_inst_o  = id_inst_q;
  assign id_valid_o = id_valid_q;

endmodule
